// File: rtl/nano_mem_trace_if.sv
// Purpose: CPU word bus plus trace drain port of nano_mem_trace, bundled as one interface.
// Latency: no storage here; timing is set by the design behind the slave modport.
// Backpressure: trace_valid/trace_ready handshake on the trace side; the CPU side never stalls.
//
// Signals:
//   ce, we, address[7:0], dataW[15:0]  CPU -> memory request
//   dataR[15:0]                        memory -> CPU read data (combinational)
//   trace_valid, trace_addr[7:0], trace_data[15:0]  FIFO head toward the consumer
//   trace_ready                        consumer accepts the head entry
//   trace_count[4:0], trace_overflow   FIFO occupancy and sticky drop flag
// Modports: slave = memory/trace block, master = CPU and trace consumer side.
interface nano_mem_trace_if;
  logic        ce;
  logic        we;
  logic [7:0]  address;
  logic [15:0] dataW;
  logic [15:0] dataR;
  logic        trace_valid;
  logic        trace_ready;
  logic [7:0]  trace_addr;
  logic [15:0] trace_data;
  logic [4:0]  trace_count;
  logic        trace_overflow;

  modport slave (
    input  ce, we, address, dataW, trace_ready,
    output dataR, trace_valid, trace_addr, trace_data, trace_count, trace_overflow
  );

  modport master (
    output ce, we, address, dataW, trace_ready,
    input  dataR, trace_valid, trace_addr, trace_data, trace_count, trace_overflow
  );
endinterface

// File: rtl/nano_mem_trace.sv
// Purpose: 256x16 word RAM with an optional FWFT FIFO recording writes that land in [TRACE_BASE, TRACE_LIMIT].
// Latency: reads are combinational; writes and trace pushes take effect on the ck edge; FIFO head shows with zero latency.
// Backpressure: a push into a full FIFO without a same-edge pop is dropped and sets the sticky trace_overflow.
//
// Ports: ck (clock), rst (async, active low), bus (nano_mem_trace_if.slave: CPU bus + trace drain).
// Build option: define NANO_MEM_TRACE_EN to compile the trace FIFO; without it every trace output is tied to 0.
// Parameters: TRACE_DEPTH (power of two, 2..16), TRACE_BASE / TRACE_LIMIT (inclusive capture window).
module nano_mem_trace #(
  parameter int         TRACE_DEPTH = 8,
  parameter logic [7:0] TRACE_BASE  = 8'h10,
  parameter logic [7:0] TRACE_LIMIT = 8'h1F
) (
  input  logic            ck,
  input  logic            rst,
  nano_mem_trace_if.slave bus
);

  // RAM contents start at zero and are deliberately outside the reset domain:
  // a reset only clears trace bookkeeping, never stored data.
  logic [15:0] mem [0:255] = '{default: 16'h0000};

  logic wr_en;
  assign wr_en = rst && bus.ce && bus.we;

  always_ff @(posedge ck) begin
    if (wr_en) begin
      mem[bus.address] <= bus.dataW;
    end
  end

  // Read path sees the pre-edge contents during a same-address write.
  assign bus.dataR = bus.ce ? mem[bus.address] : 16'h0000;

`ifdef NANO_MEM_TRACE_EN

  localparam int         PW      = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(TRACE_DEPTH);

  logic [7:0]    fifo_addr [TRACE_DEPTH];
  logic [15:0]   fifo_data [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          overflow;

  logic in_window;
  logic push_req;
  logic full;
  logic pop;
  logic push;

  assign in_window = (bus.address >= TRACE_BASE) && (bus.address <= TRACE_LIMIT);
  assign push_req  = wr_en && in_window;
  assign full      = (count == DEPTH_C);
  assign pop       = (count != 5'd0) && bus.trace_ready;
  // When full, a same-edge pop frees the head slot, which is exactly where
  // wr_ptr points, so the new entry lands there and becomes the tail.
  assign push      = push_req && (!full || pop);

  always_ff @(posedge ck) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.address;
      fifo_data[wr_ptr] <= bus.dataW;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.trace_valid    = (count != 5'd0);
  assign bus.trace_addr     = bus.trace_valid ? fifo_addr[rd_ptr] : 8'h00;
  assign bus.trace_data     = bus.trace_valid ? fifo_data[rd_ptr] : 16'h0000;
  assign bus.trace_count    = count;
  assign bus.trace_overflow = overflow;

`else

  // Consumer handshake has nothing to act on in this build.
  logic unused_trace_ready;
  assign unused_trace_ready = bus.trace_ready;

  assign bus.trace_valid    = 1'b0;
  assign bus.trace_addr     = 8'h00;
  assign bus.trace_data     = 16'h0000;
  assign bus.trace_count    = 5'd0;
  assign bus.trace_overflow = 1'b0;

`endif

endmodule

// File: tb/tb_nano_mem_trace.sv
// Purpose: directed self-checking bench for nano_mem_trace (RAM path always, trace FIFO when NANO_MEM_TRACE_EN is defined).
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Backpressure: trace_ready is driven explicitly per vector to hold or drain the FIFO.
module tb_nano_mem_trace;

  logic ck;
  logic rst;
  int   checks;
  int   errors;

  nano_mem_trace_if bus ();

  nano_mem_trace dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    bus.ce          = 1'b0;
    bus.we          = 1'b0;
    bus.address     = 8'h00;
    bus.dataW       = 16'h0000;
    bus.trace_ready = 1'b0;
  endtask

  // One write cycle; rdy is the trace_ready level during the same edge.
  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic rdy);
    bus.ce          = 1'b1;
    bus.we          = 1'b1;
    bus.address     = a;
    bus.dataW       = d;
    bus.trace_ready = rdy;
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
    bus.ce      = 1'b1;
    bus.we      = 1'b0;
    bus.address = a;
    #1;
    chk(tag, {16'h0, bus.dataR}, {16'h0, exp});
    bus.ce = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle();
    #1;
    chk("rst_count", {27'h0, bus.trace_count}, 32'd0);
    chk("rst_valid", {31'h0, bus.trace_valid}, 32'd0);
    chk("rst_ovf",   {31'h0, bus.trace_overflow}, 32'd0);
    chk("rst_dataR_ce0", {16'h0, bus.dataR}, 32'h0);

    // Write attempt while in reset must not reach the RAM.
    bus.ce = 1'b1; bus.we = 1'b1; bus.address = 8'h30; bus.dataW = 16'hBEEF;
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rd("rst_write_blocked", 8'h30, 16'h0000);

    // Write/read basics with old-value-before-edge behaviour.
    bus.ce = 1'b1; bus.we = 1'b1; bus.address = 8'h09; bus.dataW = 16'h0005;
    #1;
    chk("wr_old_before_edge", {16'h0, bus.dataR}, 32'h0000);
    tick();
    chk("wr_new_after_edge", {16'h0, bus.dataR}, 32'h0005);
    idle();
    #1;
    chk("rd_ce0_zero", {16'h0, bus.dataR}, 32'h0000);
    chk("nowin_count", {27'h0, bus.trace_count}, 32'd0);
    rd("rd_09", 8'h09, 16'h0005);

`ifdef NANO_MEM_TRACE_EN
    // Three in-window writes held in the FIFO, then drained in order.
    for (int i = 0; i < 3; i++) wr(8'h10 + 8'(i), 16'(i + 1), 1'b0);
    chk("fill3_count", {27'h0, bus.trace_count}, 32'd3);
    chk("fill3_valid", {31'h0, bus.trace_valid}, 32'd1);
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain3_addr", {24'h0, bus.trace_addr}, 32'h10 + i);
      chk("drain3_data", {16'h0, bus.trace_data}, 32'(i + 1));
      tick();
    end
    chk("drain3_valid", {31'h0, bus.trace_valid}, 32'd0);
    chk("empty_addr0", {24'h0, bus.trace_addr}, 32'h0);
    chk("empty_data0", {16'h0, bus.trace_data}, 32'h0);
    tick();
    chk("ready_empty_noop", {27'h0, bus.trace_count}, 32'd0);
    idle();

    // Window edges: just outside on both sides, then the inclusive limit.
    wr(8'h0F, 16'h1111, 1'b0);
    wr(8'h20, 16'h2222, 1'b0);
    chk("outside_no_push", {27'h0, bus.trace_count}, 32'd0);
    wr(8'h1F, 16'h3333, 1'b0);
    chk("limit_push", {27'h0, bus.trace_count}, 32'd1);
    chk("limit_addr", {24'h0, bus.trace_addr}, 32'h1F);
    bus.trace_ready = 1'b1;
    tick();
    idle();

    // Fill to depth, one more is dropped.
    for (int i = 0; i < 8; i++) wr(8'h1F, 16'h0100 + 16'(i), 1'b0);
    chk("full_count", {27'h0, bus.trace_count}, 32'd8);
    chk("full_no_ovf", {31'h0, bus.trace_overflow}, 32'd0);
    wr(8'h1F, 16'h0108, 1'b0);
    chk("drop_count", {27'h0, bus.trace_count}, 32'd8);
    chk("drop_ovf", {31'h0, bus.trace_overflow}, 32'd1);

    // Push and pop together while full: 0x0100 leaves, 0xABCD joins at the tail.
    wr(8'h10, 16'hABCD, 1'b1);
    chk("full_pushpop_count", {27'h0, bus.trace_count}, 32'd8);
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain8_addr", {24'h0, bus.trace_addr}, (i == 7) ? 32'h10 : 32'h1F);
      chk("drain8_data", {16'h0, bus.trace_data}, (i == 7) ? 32'hABCD : 32'h0101 + i);
      tick();
    end
    chk("drain8_empty", {27'h0, bus.trace_count}, 32'd0);
    chk("ovf_sticky", {31'h0, bus.trace_overflow}, 32'd1);
    idle();

    // Empty FIFO with simultaneous push and ready: only the push happens.
    wr(8'h11, 16'h0777, 1'b1);
    chk("empty_pushpop_count", {27'h0, bus.trace_count}, 32'd1);
    chk("empty_pushpop_data", {16'h0, bus.trace_data}, 32'h0777);
    bus.trace_ready = 1'b1;
    tick();
    idle();
`else
    // Trace disabled: in-window traffic leaves every trace output at 0.
    for (int i = 0; i < 9; i++) wr(8'h1F, 16'h0100 + 16'(i), 1'b1);
    chk("off_count", {27'h0, bus.trace_count}, 32'd0);
    chk("off_valid", {31'h0, bus.trace_valid}, 32'd0);
    chk("off_ovf",   {31'h0, bus.trace_overflow}, 32'd0);
    chk("off_addr",  {24'h0, bus.trace_addr}, 32'h0);
    chk("off_data",  {16'h0, bus.trace_data}, 32'h0);
    rd("off_ram_1F", 8'h1F, 16'h0108);
`endif

    // Mid-cycle reset with four entries queued (when traced); RAM must survive.
    for (int i = 0; i < 4; i++) wr(8'h10, 16'h00A0 + 16'(i), 1'b0);
`ifdef NANO_MEM_TRACE_EN
    chk("pre_rst_count", {27'h0, bus.trace_count}, 32'd4);
`endif
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", {27'h0, bus.trace_count}, 32'd0);
    chk("async_rst_ovf",   {31'h0, bus.trace_overflow}, 32'd0);
    chk("async_rst_valid", {31'h0, bus.trace_valid}, 32'd0);
    rd("rst_ram_kept", 8'h10, 16'h00A3);
    tick();
    rst = 1'b1;
    tick();
    rd("post_rst_ram", 8'h10, 16'h00A3);
    rd("ram_09_kept", 8'h09, 16'h0005);
    chk("post_rst_count", {27'h0, bus.trace_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
